// File: rtl/pwr_switch_emu_pkg.sv
// Shared types and defaults for the power-switch acknowledge emulator.
package pwr_switch_emu_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_RAMP   = 1'b1
  } ch_state_e;

  localparam int LAT_W_DEF = 8;

endpackage

// File: rtl/pwr_switch_ack_emu_if.sv
// Bus between a power manager and the switch-acknowledge emulator.
// Protocol: switch_i is a level request per channel; ack_o follows it after the
// programmed latency, busy_o flags a ramp in flight and done_o pulses when ack_o moves.
interface pwr_switch_ack_emu_if #(
  parameter int N_CH  = 4,
  parameter int LAT_W = 8
);
  logic [N_CH-1:0]       switch_i;
  logic [N_CH*LAT_W-1:0] rise_lat_i;
  logic [N_CH*LAT_W-1:0] fall_lat_i;
  logic [N_CH-1:0]       hold_i;
  logic [N_CH-1:0]       ack_o;
  logic [N_CH-1:0]       busy_o;
  logic [N_CH-1:0]       done_o;

  modport master (
    output switch_i, rise_lat_i, fall_lat_i, hold_i,
    input  ack_o, busy_o, done_o
  );

  modport slave (
    input  switch_i, rise_lat_i, fall_lat_i, hold_i,
    output ack_o, busy_o, done_o
  );
endinterface

// File: rtl/pwr_switch_ack_ch.sv
// One emulated power-switch channel: STABLE/RAMP FSM with a latency down-counter.
module pwr_switch_ack_ch
  import pwr_switch_emu_pkg::*;
#(
  parameter int   LAT_W   = LAT_W_DEF,
  parameter logic ACK_RST = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             switch_i,
  input  logic             hold_i,
  input  logic [LAT_W-1:0] rise_lat_i,
  input  logic [LAT_W-1:0] fall_lat_i,
  output logic             ack_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [LAT_W-1:0] CNT_ONE = LAT_W'(1);

  ch_state_e        state_q, state_d;
  logic             target_q, target_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic [LAT_W-1:0] lat_sel;

  // Latency of the level currently requested; only consumed when a ramp (re)starts.
  assign lat_sel = switch_i ? rise_lat_i : fall_lat_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_STABLE;
      target_q <= ACK_RST;
      cnt_q    <= '0;
      ack_q    <= ACK_RST;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    ack_d    = ack_q;
    done_d   = 1'b0;
    case (state_q)
      ST_STABLE: begin
        if (switch_i != ack_q) begin
          target_d = switch_i;
          cnt_d    = lat_sel;
          state_d  = ST_RAMP;
        end
      end
      ST_RAMP: begin
        // A reversal wins over hold; falling back to ack ends the ramp silently.
        if (switch_i != target_q) begin
          target_d = switch_i;
          cnt_d    = lat_sel;
          if (switch_i == ack_q) state_d = ST_STABLE;
        end else if (!hold_i) begin
          if (cnt_q == '0) begin
            ack_d   = target_q;
            done_d  = 1'b1;
            state_d = ST_STABLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      default: state_d = ST_STABLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == ST_RAMP);
    ack_o  = ack_q;
    done_o = done_q;
  end

endmodule

// File: rtl/pwr_switch_ack_emu.sv
// Multi-channel power-switch acknowledge emulator; channels are fully independent.
module pwr_switch_ack_emu
  import pwr_switch_emu_pkg::*;
#(
  parameter int              N_CH    = 4,
  parameter int              LAT_W   = LAT_W_DEF,
  parameter logic [N_CH-1:0] ACK_RST = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pwr_switch_ack_emu_if.slave  bus
);

  logic [N_CH-1:0] ack_w;
  logic [N_CH-1:0] busy_w;
  logic [N_CH-1:0] done_w;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    pwr_switch_ack_ch #(
      .LAT_W   (LAT_W),
      .ACK_RST (ACK_RST[c])
    ) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .switch_i   (bus.switch_i[c]),
      .hold_i     (bus.hold_i[c]),
      .rise_lat_i (bus.rise_lat_i[c*LAT_W +: LAT_W]),
      .fall_lat_i (bus.fall_lat_i[c*LAT_W +: LAT_W]),
      .ack_o      (ack_w[c]),
      .busy_o     (busy_w[c]),
      .done_o     (done_w[c])
    );
  end

  assign bus.ack_o  = ack_w;
  assign bus.busy_o = busy_w;
  assign bus.done_o = done_w;

endmodule

// File: doc/pwr_switch_ack_emu.md
PWR_SWITCH_ACK_EMU -- requirements
Module: pwr_switch_ack_emu

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent power-switch channels (1..32).
REQ-002 SHALL have parameter LAT_W, default 8: width of each latency value and counter.
REQ-003 SHALL have parameter ACK_RST, default all-zero [N_CH-1:0]: per-channel ack_o value after reset.
REQ-004 SHALL have port clk_i  input  1: single clock, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port switch_i  input  N_CH: per-channel switch request level from the power manager.
REQ-007 SHALL have port rise_lat_i  input  N_CH*LAT_W: per-channel latency for a 0->1 transition, channel c at bits [c*LAT_W +: LAT_W].
REQ-008 SHALL have port fall_lat_i  input  N_CH*LAT_W: per-channel latency for a 1->0 transition, same packing.
REQ-009 SHALL have port hold_i  input  N_CH: per-channel counter freeze, emulating a stalled supply ramp.
REQ-010 SHALL have port ack_o  output  N_CH: per-channel delayed switch acknowledge.
REQ-011 SHALL have port busy_o  output  N_CH: channel is in RAMP.
REQ-012 SHALL have port done_o  output  N_CH: one-cycle pulse when ack_o of the channel changes.

Function
REQ-013 Each channel SHALL run an independent two-state FSM, STABLE and RAMP, plus registers target, cnt[LAT_W], ack.
REQ-014 In STABLE with switch_i[c] == ack_o[c], the channel SHALL stay in STABLE with no register change.
REQ-015 In STABLE with switch_i[c] != ack_o[c], the channel SHALL set target to switch_i[c] and load cnt with rise_lat (target 1) or fall_lat (target 0). It SHALL then enter RAMP.
REQ-016 Latency inputs SHALL be sampled only when a ramp starts or restarts; changes during RAMP SHALL have no effect on the running ramp.
REQ-017 In RAMP with hold_i[c]=1 and switch_i[c]==target, all channel registers SHALL hold.
REQ-018 In RAMP with cnt==0 and hold_i[c]=0, ack SHALL take target, done_o[c] SHALL pulse for one cycle, and the FSM SHALL return to STABLE.
REQ-019 In RAMP with cnt!=0 and hold_i[c]=0, cnt SHALL decrement by 1 (no wrap below 0).
REQ-020 Resulting latency: for an unheld ramp, ack_o SHALL change exactly L+1 rising edges after the edge that first samples the new switch_i level; L=0 gives a one-cycle delay.
REQ-021 Reversal: in RAMP with switch_i[c] != target, target SHALL take switch_i[c] and cnt SHALL reload with the latency of the new target. This SHALL happen regardless of hold_i. If the new target equals ack, the FSM SHALL go to STABLE without a done_o pulse.
REQ-022 A switch_i glitch shorter than L+1 cycles SHALL NOT change ack_o.
REQ-023 busy_o[c] SHALL be 1 exactly while the channel state is RAMP; ack_o and done_o SHALL be registered outputs.
REQ-024 Channels SHALL NOT interact; simultaneous events on different channels SHALL each follow REQ-014..021.

Reset
REQ-025 With rst_i=1 at a rising edge, every channel SHALL enter STABLE with ack_o=ACK_RST, target=ACK_RST, cnt=0, busy_o=0 and done_o=0.
REQ-026 Reset SHALL override any in-progress RAMP or hold; no done_o SHALL be issued for an aborted ramp.
REQ-027 In the first cycle after reset, if switch_i differs from ACK_RST, a ramp SHALL start per REQ-015.

Structure
REQ-028 Package pwr_switch_emu_pkg SHALL hold the channel state enum (STABLE, RAMP) and the default LAT_W constant.
REQ-029 Per-channel logic SHALL live in sub-module pwr_switch_ack_ch, instantiated N_CH times by a generate loop; the top SHALL only unpack the latency vectors.
REQ-030 The block SHALL be synthesizable, with no force statements and no hierarchical references, so that it works under both Verilator and event simulators.

Verification
REQ-031 Case: N_CH=4, rise_lat=15, switch_i[0] 0->1 at edge 10. Required: ack_o[0]=1 from edge 26, busy_o[0]=1 for edges 11..26, done_o[0] pulse at edge 26.
REQ-032 Case: fall_lat=3, rise_lat=15, ch1 ack=1, switch_i[1] 1->0 at edge 5 and back to 1 at edge 7. Required: ack_o[1] never leaves 1, no done_o, busy_o[1]=0 from edge 8.
REQ-033 Case: rise_lat=4, hold_i[2]=1 for 6 cycles mid-ramp. Required: ack_o[2] rises exactly 6 cycles later than in the unheld case.
REQ-034 Case: lat=0 on all channels and switch_i=4'b1111 at one edge. Required: ack_o=4'b1111 one edge later and done_o=4'b1111 for one cycle.
REQ-035 Case: rst_i asserted mid-ramp with ACK_RST=4'b0101. Required: ack_o=4'b0101 and busy_o=0 on the reset edge, then new ramps for any channel with switch_i!=ack_o.
REQ-036 Case: rise_lat changed from 10 to 2 during a running ramp. Required: the ramp still completes after 11 cycles.
